if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage ARM pipeline. It directly feeds the decode stage. The block holds the program counter and drives a variable-latency instruction-memory request/acknowledge interface. It also contains the IF/ID pipeline register, with a valid bit and a one-entry skid buffer. Branch redirects from EXE flush in-flight fetches, and hazard freezes from the hazard-detect unit hold the decode-facing outputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall from the hazard-detect unit; ID cannot accept a new instruction
- branch_taken  in  1  single-cycle redirect from EXE
- branch_addr  in  32  redirect target; bits [1:0] are ignored and treated as 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; held stable while imem_req=1 until acknowledged
- imem_ack  in  1  memory completion, sampled only when imem_req=1
- imem_rdata  in  32  instruction word, valid in the imem_ack cycle
- if_pc  out  32  address+4 of the held instruction, to ID
- if_instr  out  32  held instruction, to ID
- if_valid  out  1  if_instr/if_pc are valid

## Operation
- Registers:
  - pc[31:0]
  - state ∈ {RUN, DRAIN, HOLD}
  - skid_instr, skid_pc
  - if_instr, if_pc, if_valid
- imem_addr = pc.
- imem_req = 1 in RUN and DRAIN; imem_req = 0 in HOLD.
- Reset: pc=RESET_PC, state=RUN, if_instr=0, if_pc=0, if_valid=0, skid cleared. During rst, imem_req reads 0.
- Accept condition: accept = !freeze | !if_valid.
- RUN, imem_ack=1, no branch:
  - pc ← pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If accept: if_instr ← imem_rdata, if_pc ← pc+4, if_valid ← 1.
  - Else: skid ← {imem_rdata, pc+4}, state ← HOLD.
- RUN, imem_ack=0, no branch:
  - pc holds, state holds.
  - If !freeze: if_valid ← 0. A bubble is presented to ID; if_instr and if_pc values are don't-care.
- freeze=1 with no accepted load: if_instr, if_pc and if_valid hold.
- HOLD:
  - While freeze=1, everything holds.
  - On freeze=0: if_instr/if_pc ← skid, if_valid ← 1, state ← RUN.
- DRAIN:
  - The outstanding request for the stale address stays asserted, with imem_addr held at the stale address.
  - On imem_ack: rdata is discarded, pc ← the stored redirect target, state ← RUN.
  - if_valid stays 0.
- Redirect target storage: a separate register redir_pc. pc itself stays frozen while in DRAIN so that imem_addr remains stable.
- branch_taken=1 has highest priority over freeze, ack and state:
  - Always: if_valid ← 0, skid cleared.
  - RUN with imem_ack=1: rdata is discarded, pc ← branch_addr, state stays RUN.
  - RUN with imem_ack=0: redir_pc ← branch_addr, state ← DRAIN.
  - DRAIN with imem_ack=0: redir_pc ← the newest branch_addr; the latest redirect wins.
  - DRAIN with imem_ack=1: pc ← branch_addr, state ← RUN.
  - HOLD: pc ← branch_addr, state ← RUN.
- Reset mid-transaction abandons any outstanding request. Instruction memory is reset by the same rst.

## Timing
- Zero-wait memory (ack in the request cycle):
  - First if_valid=1 one cycle after rst deasserts.
  - Throughput is one instruction per cycle.
- N-cycle ack latency: if_valid rises on the edge that samples imem_ack.
- Redirect: the first request to branch_addr appears the cycle after branch_taken (RUN/HOLD), or the cycle after the stale ack (DRAIN).
- HOLD release: if_valid=1 with the skid contents on the edge after freeze falls. imem_req reasserts in that same following cycle.
- No combinational path from imem_rdata to the if_* outputs.
- imem_req depends only on state and rst.

## Test plan
- Reset then zero-wait memory returning addr+0x100:
  - The 1st cycle after reset shows imem_addr=0.
  - if_instr is 0x100, 0x104, 0x108 on successive cycles.
  - if_pc is 4, 8, 12 on those same cycles.
- Ack latency of 3 cycles:
  - imem_addr holds at 0x0 for 3 cycles.
  - if_valid pulses once per 3 cycles, with if_valid=0 between.
- freeze=1 for 4 cycles while if_valid=1 and a new ack arrives:
  - The outputs hold the old word and state=HOLD, with imem_req=0.
  - When freeze drops, the skid word appears, followed by the next fetch at +4.
- branch_taken with branch_addr=0x2003 while a 3-cycle fetch to 0x10 is outstanding:
  - imem_addr stays 0x10 until the ack, and that rdata is dropped.
  - The next request is to 0x2000.
  - if_valid is never 1 for the 0x10 word.
- branch_taken concurrent with freeze=1 and a full skid (HOLD):
  - Outputs are flushed (if_valid=0).
  - The next imem_addr is branch_addr.
- pc=0xFFFF_FFFC fetched: the next imem_addr is 0x0000_0000 and if_pc=0. Assert rst mid-fetch: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: program counter, instruction-memory request/ack handshake,
// and the IF/ID register with a one-entry skid buffer.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | fetching at r_pc, loading IF/ID on each ack
// ST_DRAIN | waiting out a stale request after a redirect; target in r_redir_pc
// ST_HOLD  | ID frozen with if_* full; the extra word is parked in the skid
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;

    state_t      w_state;
    logic [31:0] w_pc;
    logic [31:0] w_redir_pc;
    logic [31:0] w_skid_instr;
    logic [31:0] w_skid_pc;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic        w_if_valid;

    logic [31:0] w_br_addr;
    logic [31:0] w_pc_inc;
    logic        w_accept;

    // Low address bits are forced to zero so fetches stay word aligned.
    assign w_br_addr = branch_addr & 32'hFFFF_FFFC;
    assign w_pc_inc  = r_pc + 32'd4;
    assign w_accept  = !freeze || !r_if_valid;

    // Request depends only on state and reset; address is the registered PC.
    assign imem_req  = !rst && (r_state != ST_HOLD);
    assign imem_addr = r_pc;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_valid  = r_if_valid;

    // Next-state and datapath update; redirect overrides freeze, ack and state.
    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_redir_pc   = r_redir_pc;
        w_skid_instr = r_skid_instr;
        w_skid_pc    = r_skid_pc;
        w_if_instr   = r_if_instr;
        w_if_pc      = r_if_pc;
        w_if_valid   = r_if_valid;

        if (branch_taken) begin
            w_if_valid   = 1'b0;
            w_skid_instr = 32'd0;
            w_skid_pc    = 32'd0;
            case (r_state)
                ST_RUN: begin
                    if (imem_ack) begin
                        w_pc = w_br_addr;
                    end else begin
                        w_redir_pc = w_br_addr;
                        w_state    = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        w_pc    = w_br_addr;
                        w_state = ST_RUN;
                    end else begin
                        w_redir_pc = w_br_addr;
                    end
                end
                default: begin
                    w_pc    = w_br_addr;
                    w_state = ST_RUN;
                end
            endcase
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (imem_ack) begin
                        w_pc = w_pc_inc;
                        if (w_accept) begin
                            w_if_instr = imem_rdata;
                            w_if_pc    = w_pc_inc;
                            w_if_valid = 1'b1;
                        end else begin
                            w_skid_instr = imem_rdata;
                            w_skid_pc    = w_pc_inc;
                            w_state      = ST_HOLD;
                        end
                    end else if (!freeze) begin
                        w_if_valid = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    w_if_valid = 1'b0;
                    if (imem_ack) begin
                        w_pc    = r_redir_pc;
                        w_state = ST_RUN;
                    end
                end
                default: begin
                    if (!freeze) begin
                        w_if_instr = r_skid_instr;
                        w_if_pc    = r_skid_pc;
                        w_if_valid = 1'b1;
                        w_state    = ST_RUN;
                    end
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC & 32'hFFFF_FFFC;
            r_redir_pc   <= 32'd0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_if_instr   <= 32'd0;
            r_if_pc      <= 32'd0;
            r_if_valid   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_redir_pc   <= w_redir_pc;
            r_skid_instr <= w_skid_instr;
            r_skid_pc    <= w_skid_pc;
            r_if_instr   <= w_if_instr;
            r_if_pc      <= w_if_pc;
            r_if_valid   <= w_if_valid;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks plus a scoreboard of fetched words for if_stage.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mem_lat;
    int   mem_cnt;
    bit   stale;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    // Memory: acks in the mem_lat-th cycle of a request, data = addr + 0x100.
    assign imem_ack   = imem_req && (mem_cnt >= mem_lat - 1);
    assign imem_rdata = imem_addr + 32'h100;

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard producer: each delivered word is expected once, unless flushed.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            stale <= 1'b0;
        end else if (branch_taken) begin
            sb.delete();
            stale <= imem_req && !imem_ack;
        end else if (imem_ack) begin
            if (!stale) sb.push_back('{pc: imem_addr + 32'd4, instr: imem_rdata});
            stale <= 1'b0;
        end
    end

    // Scoreboard consumer: ID takes the word when valid and not frozen.
    always @(negedge clk) begin
        if (!rst && if_valid && !freeze) begin
            chk("sb_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("sb_pc", if_pc, sb[0].pc);
                chk("sb_instr", if_instr, sb[0].instr);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        mem_lat      = lat;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        mem_lat      = 1;

        // Reset values, then zero-wait streaming.
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rst = 1'b0;
        #1;
        chk("zw_addr0", imem_addr, 32'd0);
        chk("zw_req", 32'(imem_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("zw_valid", 32'(if_valid), 32'd1);
            chk("zw_instr", if_instr, 32'h100 + 32'(4 * k));
            chk("zw_pc", if_pc, 32'(4 * (k + 1)));
        end

        // Three-cycle ack latency.
        do_reset(3);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                chk("lat_addr", imem_addr, 32'(4 * r));
                tick();
                chk("lat_valid", 32'(if_valid), (k == 2) ? 32'd1 : 32'd0);
                if (k == 2) chk("lat_instr", if_instr, 32'h100 + 32'(4 * r));
            end
        end

        // Freeze with a new ack: skid captures it, HOLD drops the request.
        do_reset(1);
        tick();
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_instr", if_instr, 32'h100);
            chk("hold_pc", if_pc, 32'd4);
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_req", 32'(imem_req), 32'd0);
        end
        freeze = 1'b0;
        tick();
        chk("rel_instr", if_instr, 32'h104);
        chk("rel_pc", if_pc, 32'd8);
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'd8);
        tick();
        chk("rel_next", if_instr, 32'h108);
        chk("rel_next_pc", if_pc, 32'd12);

        // Redirect while a slow fetch to 0x10 is outstanding.
        do_reset(1);
        for (int k = 0; k < 4; k++) tick();
        chk("br_pre_addr", imem_addr, 32'h10);
        mem_lat      = 3;
        branch_taken = 1'b1;
        branch_addr  = 32'h2003;
        tick();
        branch_taken = 1'b0;
        chk("drain_valid0", 32'(if_valid), 32'd0);
        chk("drain_addr0", imem_addr, 32'h10);
        chk("drain_req", 32'(imem_req), 32'd1);
        tick();
        chk("drain_valid1", 32'(if_valid), 32'd0);
        chk("drain_addr1", imem_addr, 32'h10);
        tick();
        chk("drain_valid2", 32'(if_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h2000);
        mem_lat = 1;
        tick();
        chk("redir_instr", if_instr, 32'h2100);
        chk("redir_pc", if_pc, 32'h2004);
        chk("redir_valid", 32'(if_valid), 32'd1);

        // Redirect in HOLD with freeze still high.
        do_reset(1);
        tick();
        freeze = 1'b1;
        tick();
        chk("hb_req", 32'(imem_req), 32'd0);
        branch_taken = 1'b1;
        branch_addr  = 32'h3000;
        tick();
        branch_taken = 1'b0;
        chk("hb_flush", 32'(if_valid), 32'd0);
        chk("hb_addr", imem_addr, 32'h3000);
        chk("hb_req2", 32'(imem_req), 32'd1);
        freeze = 1'b0;
        tick();
        chk("hb_instr", if_instr, 32'h3100);
        chk("hb_pc", if_pc, 32'h3004);

        // PC wrap at the top of the address space.
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_flush", 32'(if_valid), 32'd0);
        tick();
        chk("wrap_next", imem_addr, 32'd0);
        chk("wrap_ifpc", if_pc, 32'd0);
        chk("wrap_instr", if_instr, 32'h0000_00FC);
        tick();
        chk("wrap_instr2", if_instr, 32'h100);

        // Reset in the middle of a pending fetch with a held word.
        freeze  = 1'b1;
        mem_lat = 3;
        tick();
        chk("mid_held", 32'(if_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_req", 32'(imem_req), 32'd0);
        tick();
        chk("mid_valid", 32'(if_valid), 32'd0);
        chk("mid_instr", if_instr, 32'd0);
        chk("mid_pc", if_pc, 32'd0);
        chk("mid_addr", imem_addr, 32'd0);
        rst     = 1'b0;
        freeze  = 1'b0;
        mem_lat = 1;
        for (int k = 0; k < 3; k++) tick();
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
